// File: rtl/uart_record_formatter.sv
// uart_record_formatter
// Pops one packed record of NUM_FIELDS words from a FIFO and sends it to a
// byte UART as ASCII hex text. Fields are separated by SEP_CHAR and the record
// ends with CR LF. Run-time options: leading-zero suppression, lowercase
// digits, and a two-digit sequence-number prefix followed by ':'.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a record in the FIFO while enabled
// POP   | fifo_rd_en strobe
// LATCH | capture record and mode inputs, launch the first byte
// SEQ   | sequence prefix: two hex digits, then ':'
// DIGIT | hex digits of the current field, MSB nibble first
// SEP   | separator between fields
// CR    | carriage return
// LF    | line feed; on its done the record counters advance
//
// Inside every sending state, pend_q marks the gap cycle that follows a
// uart_tx_done. The byte itself is launched from the next-state values, so
// LATCH can start the first byte one cycle after the data arrives.
module uart_record_formatter #(
  parameter int         WORD_WIDTH = 32,
  parameter int         NUM_FIELDS = 3,
  parameter logic [7:0] SEP_CHAR   = 8'h2C
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fsm_en,
  input  logic                             suppress_lz,
  input  logic                             lowercase,
  input  logic                             add_seq,
  input  logic                             uart_tx_done,
  output logic                             uart_start_tx,
  output logic [7:0]                       uart_tx_din,
  input  logic [WORD_WIDTH*NUM_FIELDS-1:0] fifo_rd_data,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  output logic                             busy,
  output logic [15:0]                      records_sent
);

  localparam int         ND     = WORD_WIDTH / 4;
  localparam int         RW     = WORD_WIDTH * NUM_FIELDS;
  localparam logic [4:0] LAST_N = 5'(ND - 1);
  localparam logic [2:0] LAST_F = 3'(NUM_FIELDS - 1);
  localparam logic [4:0] SEQ_COLON = 5'd2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEQ   = 3'd3;
  localparam logic [2:0] S_DIGIT = 3'd4;
  localparam logic [2:0] S_SEP   = 3'd5;
  localparam logic [2:0] S_CR    = 3'd6;
  localparam logic [2:0] S_LF    = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [2:0]    field_q, field_d;
  logic [4:0]    nib_q, nib_d;
  logic [RW-1:0] data_q, data_d;
  logic          slz_q, slz_d;
  logic          lc_q, lc_d;
  logic          pend_q, pend_d;
  logic [7:0]    seq_q, seq_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          rd_en_q, rd_en_d;
  logic [7:0]    din_q, din_d;
  logic          done_ok;

  function automatic logic [7:0] hex_char(input logic [3:0] n, input logic lc);
    logic [7:0] v;
    v = {4'h0, n};
    if (n < 4'd10) return 8'h30 + v;
    return (lc ? 8'h61 : 8'h41) + v - 8'd10;
  endfunction

  // Field 0 sits in the MSBs of the record.
  function automatic logic [WORD_WIDTH-1:0] field_word(input logic [RW-1:0] rec,
                                                       input logic [2:0] f);
    return rec[(NUM_FIELDS - 1 - int'(f)) * WORD_WIDTH +: WORD_WIDTH];
  endfunction

  // Nibble index 0 is the most significant nibble of the field.
  function automatic logic [3:0] nib_of(input logic [WORD_WIDTH-1:0] w,
                                        input logic [4:0] n);
    return w[(ND - 1 - int'(n)) * 4 +: 4];
  endfunction

  // First nibble to print; an all-zero field still prints its last nibble.
  function automatic logic [4:0] first_nib(input logic [WORD_WIDTH-1:0] w,
                                           input logic slz);
    logic [4:0] r;
    r = 5'd0;
    if (slz) begin
      r = LAST_N;
      for (int i = ND - 1; i >= 0; i--) begin
        if (nib_of(w, 5'(i)) != 4'h0) r = 5'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] byte_for(input logic [2:0]    st,
                                          input logic [2:0]    f,
                                          input logic [4:0]    n,
                                          input logic [RW-1:0] rec,
                                          input logic          lc,
                                          input logic [7:0]    seq);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_SEQ: begin
        if (n == SEQ_COLON) b = 8'h3A;
        else if (n == 5'd0) b = hex_char(seq[7:4], lc);
        else                b = hex_char(seq[3:0], lc);
      end
      S_DIGIT: b = hex_char(nib_of(field_word(rec, f), n), lc);
      S_SEP:   b = SEP_CHAR;
      S_CR:    b = 8'h0D;
      S_LF:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign done_ok = uart_tx_done && !pend_q && !start_q;

  // Next-state, position and byte-launch logic.
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    nib_d   = nib_q;
    data_d  = data_q;
    slz_d   = slz_q;
    lc_d    = lc_q;
    pend_d  = pend_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    rd_en_d = 1'b0;
    din_d   = din_q;
    if (!fsm_en) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      din_d   = 8'h00;
    end else begin
      if (pend_q) begin
        start_d = 1'b1;
        pend_d  = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            state_d = S_POP;
            rd_en_d = 1'b1;
          end
        end
        S_POP: state_d = S_LATCH;
        S_LATCH: begin
          data_d  = fifo_rd_data;
          slz_d   = suppress_lz;
          lc_d    = lowercase;
          field_d = 3'd0;
          start_d = 1'b1;
          if (add_seq) begin
            state_d = S_SEQ;
            nib_d   = 5'd0;
          end else begin
            state_d = S_DIGIT;
            nib_d   = first_nib(field_word(fifo_rd_data, 3'd0), suppress_lz);
          end
        end
        S_SEQ: begin
          if (done_ok) begin
            pend_d = 1'b1;
            if (nib_q == SEQ_COLON) begin
              state_d = S_DIGIT;
              nib_d   = first_nib(field_word(data_q, 3'd0), slz_q);
            end else begin
              nib_d = nib_q + 5'd1;
            end
          end
        end
        S_DIGIT: begin
          if (done_ok) begin
            pend_d = 1'b1;
            if (nib_q == LAST_N) state_d = (field_q == LAST_F) ? S_CR : S_SEP;
            else                 nib_d   = nib_q + 5'd1;
          end
        end
        S_SEP: begin
          if (done_ok) begin
            pend_d  = 1'b1;
            state_d = S_DIGIT;
            field_d = field_q + 3'd1;
            nib_d   = first_nib(field_word(data_q, field_q + 3'd1), slz_q);
          end
        end
        S_CR: begin
          if (done_ok) begin
            pend_d  = 1'b1;
            state_d = S_LF;
          end
        end
        S_LF: begin
          if (done_ok) begin
            state_d = S_IDLE;
            seq_d   = seq_q + 8'd1;
            cnt_d   = cnt_q + 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (start_d) din_d = byte_for(state_d, field_d, nib_d, data_d, lc_d, seq_q);
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      field_q <= 3'd0;
      nib_q   <= 5'd0;
      data_q  <= '0;
      slz_q   <= 1'b0;
      lc_q    <= 1'b0;
      pend_q  <= 1'b0;
      seq_q   <= 8'd0;
      cnt_q   <= 16'd0;
      start_q <= 1'b0;
      rd_en_q <= 1'b0;
      din_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      nib_q   <= nib_d;
      data_q  <= data_d;
      slz_q   <= slz_d;
      lc_q    <= lc_d;
      pend_q  <= pend_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      rd_en_q <= rd_en_d;
      din_q   <= din_d;
    end
  end

  assign uart_start_tx = start_q;
  assign uart_tx_din   = din_q;
  assign fifo_rd_en    = rd_en_q;
  assign busy          = (state_q != S_IDLE);
  assign records_sent  = cnt_q;

endmodule

// File: tb/tb_uart_record_formatter.sv
// Testbench for uart_record_formatter: FIFO and UART models, a text-level
// reference model feeding an expected-byte queue, and a monitor that pops and
// compares every byte the formatter launches.
module tb_uart_record_formatter;
  localparam int W  = 32;
  localparam int NF = 3;
  localparam int RW = W * NF;

  logic          clk = 1'b0;
  logic          reset, fsm_en, suppress_lz, lowercase, add_seq, uart_tx_done;
  logic          uart_start_tx;
  logic [7:0]    uart_tx_din;
  logic [RW-1:0] fifo_rd_data;
  logic          fifo_empty, fifo_rd_en, busy;
  logic [15:0]   records_sent;

  uart_record_formatter #(.WORD_WIDTH(W), .NUM_FIELDS(NF), .SEP_CHAR(8'h2C)) dut (
    .clk(clk), .reset(reset), .fsm_en(fsm_en), .suppress_lz(suppress_lz),
    .lowercase(lowercase), .add_seq(add_seq), .uart_tx_done(uart_tx_done),
    .uart_start_tx(uart_start_tx), .uart_tx_din(uart_tx_din),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .busy(busy), .records_sent(records_sent));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [RW-1:0] rec_q[$];
  logic [7:0]    exp_q[$];
  bit            first_q[$];
  int  rem = 0, lat = 4;
  int  last_done_cyc = 0, last_rden_cyc = 0, lf_done_cyc = 0;
  bit  lf_pending = 0, have_lf = 0, b2b = 0;
  int  starts_seen = 0, pops_seen = 0;
  logic [7:0]  tb_seq = 8'd0;
  logic [15:0] tb_cnt = 16'd0;
  int  checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required at cycle %0d", name, cyc);
  endtask

  // Reference text for one record: hex per field, optional zero stripping,
  // optional "SS:" prefix, fields joined by ',' and terminated by CR LF.
  function automatic void push_expect(input logic [RW-1:0] rec, input bit slz,
                                      input bit lc, input bit aseq);
    string      hx;
    logic [7:0] bs[$];
    logic [7:0] dg[$];
    logic [31:0] w;
    hx = lc ? "0123456789abcdef" : "0123456789ABCDEF";
    if (aseq) begin
      bs.push_back(hx[int'(tb_seq[7:4])]);
      bs.push_back(hx[int'(tb_seq[3:0])]);
      bs.push_back(8'h3A);
    end
    for (int f = 0; f < NF; f++) begin
      w = rec[RW - 1 - 32 * f -: 32];
      dg.delete();
      for (int n = 7; n >= 0; n--) dg.push_back(hx[int'(w[4 * n +: 4])]);
      if (slz) while (dg.size() > 1 && dg[0] == 8'h30) void'(dg.pop_front());
      foreach (dg[k]) bs.push_back(dg[k]);
      if (f < NF - 1) bs.push_back(8'h2C);
    end
    bs.push_back(8'h0D);
    bs.push_back(8'h0A);
    foreach (bs[k]) begin
      exp_q.push_back(bs[k]);
      first_q.push_back(k == 0);
    end
    tb_seq = tb_seq + 8'd1;
    tb_cnt = tb_cnt + 16'd1;
  endfunction

  // Environment: UART responder, byte monitor and FIFO model, all on negedge.
  initial begin
    logic [7:0] eb;
    bit         fb;
    forever begin
      @(negedge clk);
      uart_tx_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          uart_tx_done  = 1'b1;
          last_done_cyc = cyc;
          if (lf_pending) begin
            lf_done_cyc = cyc;
            lf_pending  = 0;
            have_lf     = 1;
          end
        end
      end
      if (uart_start_tx) begin
        starts_seen++;
        if (exp_q.size() == 0) fail("unexpected_start");
        else begin
          eb = exp_q.pop_front();
          fb = first_q.pop_front();
          chk("tx_byte", uart_tx_din, eb);
          if (fb) chk("first_byte_latency", cyc - last_rden_cyc, 2);
          else    chk("start_spacing", cyc - last_done_cyc, 2);
          if (eb == 8'h0A) lf_pending = 1;
        end
        rem = lat;
      end
      if (fifo_rd_en) begin
        pops_seen++;
        chk("one_pop_per_record", exp_q.size(), 0);
        if (b2b && have_lf) chk("pop_gap", cyc - lf_done_cyc, 2);
        last_rden_cyc = cyc;
        if (rec_q.size() == 0) fail("pop_from_empty_fifo");
        else begin
          fifo_rd_data = rec_q.pop_front();
          push_expect(fifo_rd_data, suppress_lz, lowercase, add_seq);
        end
      end
      fifo_empty = (rec_q.size() == 0);
    end
  end

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rec_q.size() == 0 && exp_q.size() == 0 && rem == 0 && !busy) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    fail("drain_timeout");
  endtask

  task automatic wait_starts(input int target);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (starts_seen >= target) return;
    end
    fail("start_timeout");
  endtask

  task automatic clear_model();
    exp_q.delete();
    first_q.delete();
    rem = 0;
    lf_pending = 0;
    have_lf = 0;
  endtask

  function automatic logic [31:0] rand_field();
    logic [31:0] r;
    r = $urandom;
    return r >> (4 * $urandom_range(0, 8));
  endfunction

  initial begin
    int s0;
    logic [15:0] r0;
    reset = 1'b1; fsm_en = 1'b0; suppress_lz = 1'b0; lowercase = 1'b0;
    add_seq = 1'b0; uart_tx_done = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_start", uart_start_tx, 0);
    chk("reset_din", uart_tx_din, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_records", records_sent, 0);
    reset = 1'b0; fsm_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_pop", pops_seen, 0);

    // Default modes, mixed record.
    s0 = starts_seen;
    rec_q.push_back({32'h00001A2B, 32'hDEADBEEF, 32'h00000000});
    wait_drain(2000);
    chk("t1_bytes", starts_seen - s0, 28);
    chk("t1_pops", pops_seen, 1);
    chk("t1_records", records_sent, 1);

    // Suppression + lowercase, with a mid-record toggle of suppress_lz.
    suppress_lz = 1'b1; lowercase = 1'b1;
    s0 = starts_seen;
    rec_q.push_back({32'h00001A2B, 32'hDEADBEEF, 32'h00000000});
    wait_starts(s0 + 1);
    suppress_lz = 1'b0;
    wait_drain(2000);
    chk("t2_bytes", starts_seen - s0, 17);
    chk("t2_records", records_sent, tb_cnt);
    lowercase = 1'b0;

    // Sequence prefix wrap over 257 records.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tb_seq = 8'd0; tb_cnt = 16'd0; clear_model();
    add_seq = 1'b1; suppress_lz = 1'b1; lat = 1; b2b = 1;
    s0 = starts_seen;
    for (int i = 0; i < 257; i++) rec_q.push_back({32'd1, 32'd2, 32'd3});
    wait_drain(20000);
    chk("t3_records", records_sent, 257);
    chk("t3_bytes", starts_seen - s0, 257 * 10);

    // Back-to-back records, UART done 10 cycles after each start.
    add_seq = 1'b0; suppress_lz = 1'b0; lat = 10; have_lf = 0;
    r0 = records_sent;
    for (int i = 0; i < 4; i++) rec_q.push_back({rand_field(), rand_field(), rand_field()});
    wait_drain(8000);
    chk("t4_records", records_sent, r0 + 16'd4);

    // Randomized batches of modes, latencies and data.
    for (int b = 0; b < 6; b++) begin
      suppress_lz = 1'($urandom_range(0, 1));
      lowercase   = 1'($urandom_range(0, 1));
      add_seq     = 1'($urandom_range(0, 1));
      lat         = $urandom_range(1, 8);
      have_lf     = 0;
      for (int i = 0; i < 4; i++) rec_q.push_back({rand_field(), rand_field(), rand_field()});
      wait_drain(8000);
      chk("rand_records", records_sent, tb_cnt);
    end

    // Enable dropped after the 5th byte.
    suppress_lz = 1'b0; lowercase = 1'b0; add_seq = 1'b0; lat = 3; b2b = 0;
    r0 = records_sent;
    s0 = starts_seen;
    rec_q.push_back({32'hCAFE0001, 32'h12345678, 32'h9ABCDEF0});
    wait_starts(s0 + 5);
    fsm_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_start", uart_start_tx, 0);
    chk("abort_din", uart_tx_din, 0);
    clear_model();
    tb_seq = tb_seq - 8'd1; tb_cnt = tb_cnt - 16'd1;
    repeat (3) @(negedge clk);
    chk("abort_records_hold", records_sent, r0);
    fsm_en = 1'b1;
    rec_q.push_back({32'h0000ABCD, 32'h00000010, 32'hFFFFFFFF});
    wait_drain(2000);
    chk("abort_resume_records", records_sent, r0 + 16'd1);

    // Asynchronous reset between edges, mid-field.
    add_seq = 1'b1;
    s0 = starts_seen;
    rec_q.push_back({32'h11112222, 32'h33334444, 32'h55556666});
    wait_starts(s0 + 6);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("areset_start", uart_start_tx, 0);
    chk("areset_din", uart_tx_din, 0);
    chk("areset_rd_en", fifo_rd_en, 0);
    chk("areset_busy", busy, 0);
    chk("areset_records", records_sent, 0);
    clear_model();
    rec_q.delete();
    tb_seq = 8'd0; tb_cnt = 16'd0;
    @(negedge clk); reset = 1'b0;
    rec_q.push_back({32'h00000000, 32'h0000000F, 32'hA0000000});
    wait_drain(2000);
    chk("areset_after_records", records_sent, 1);
    chk("final_pending_bytes", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
